// File: rtl/dual_lane_drain_sink.sv
// Consumer end of the dual-pipeline datapath: two FWFT lane FIFOs merged
// round-robin onto one ready/valid stream, with a registered stall back to both pipelines.
module dual_lane_drain_sink #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int SKID   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              in_valid_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              in_valid_2,
    output logic              global_stall,
    output logic [DATA_W-1:0] out_data,
    output logic              out_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [7:0]        drop_count,
    output logic [15:0]       xfer_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH   = CW'(DEPTH - SKID);

    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] mem2 [DEPTH];
    logic [AW-1:0]     wr1, rd1, wr2, rd2;
    logic [CW-1:0]     cnt1, cnt2, cnt1_next, cnt2_next;
    logic              rr_ptr, locked, locked_lane;
    logic              ne1, ne2, xfer;
    logic              push1, push2, pop1, pop2, drop1, drop2;
    logic [8:0]        drop_sum;

    // Output handshake: a beat moves when out_valid && out_ready on a rising
    // edge; while out_valid && !out_ready the presented lane and data are frozen.
    always_comb begin
        ne1 = (cnt1 != '0);
        ne2 = (cnt2 != '0);
        out_valid = ne1 | ne2;
        if (locked)
            out_lane = locked_lane;
        else if (ne1 && ne2)
            out_lane = rr_ptr;
        else
            out_lane = ~ne1;
        out_data = out_lane ? mem2[rd2] : mem1[rd1];
    end

    always_comb begin
        xfer  = out_valid & out_ready;
        pop1  = xfer & ~out_lane;
        pop2  = xfer & out_lane;
        push1 = in_valid_1 & ((cnt1 != FULL_CNT) | pop1);
        push2 = in_valid_2 & ((cnt2 != FULL_CNT) | pop2);
        drop1 = in_valid_1 & ~push1;
        drop2 = in_valid_2 & ~push2;

        cnt1_next = cnt1;
        if (push1 && !pop1)
            cnt1_next = cnt1 + CW'(1);
        else if (!push1 && pop1)
            cnt1_next = cnt1 - CW'(1);

        cnt2_next = cnt2;
        if (push2 && !pop2)
            cnt2_next = cnt2 + CW'(1);
        else if (!push2 && pop2)
            cnt2_next = cnt2 - CW'(1);

        // Both lanes can drop in the same cycle, so add up to two and clamp.
        drop_sum = {1'b0, drop_count} + {8'd0, drop1} + {8'd0, drop2};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr1          <= '0;
            rd1          <= '0;
            wr2          <= '0;
            rd2          <= '0;
            cnt1         <= '0;
            cnt2         <= '0;
            rr_ptr       <= 1'b0;
            locked       <= 1'b0;
            locked_lane  <= 1'b0;
            global_stall <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
            xfer_count   <= '0;
        end else begin
            if (push1) wr1 <= wr1 + AW'(1);
            if (pop1)  rd1 <= rd1 + AW'(1);
            if (push2) wr2 <= wr2 + AW'(1);
            if (pop2)  rd2 <= rd2 + AW'(1);
            cnt1 <= cnt1_next;
            cnt2 <= cnt2_next;

            if (xfer) begin
                rr_ptr     <= ~out_lane;
                xfer_count <= xfer_count + 16'd1;
            end

            locked <= out_valid & ~out_ready;
            if (out_valid && !out_ready)
                locked_lane <= out_lane;

            // Looking at next-state counts gives upstream one extra cycle of warning.
            global_stall <= (cnt1_next >= THRESH) || (cnt2_next >= THRESH);

            if (drop1 || drop2)
                overflow <= 1'b1;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push1) mem1[wr1] <= in_data_1;
        if (push2) mem2[wr2] <= in_data_2;
    end

endmodule

// File: tb/tb_dual_lane_drain_sink.sv
// Randomised and directed bench for dual_lane_drain_sink against a queue-based
// model of the lane FIFOs, round-robin merge, stall and counters.
module tb_dual_lane_drain_sink;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int SKID   = 2;
    localparam int VW     = 1 + 1 + DATA_W + 1 + 1 + 8 + 16;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_data_1, in_data_2;
    logic              in_valid_1, in_valid_2;
    logic              global_stall;
    logic [DATA_W-1:0] out_data;
    logic              out_lane;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;
    logic [7:0]        drop_count;
    logic [15:0]       xfer_count;

    dual_lane_drain_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk(clk), .reset(reset),
        .in_data_1(in_data_1), .in_valid_1(in_valid_1),
        .in_data_2(in_data_2), .in_valid_2(in_valid_2),
        .global_stall(global_stall),
        .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow), .drop_count(drop_count), .xfer_count(xfer_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard / reference model
    logic [DATA_W-1:0] exp_q1[$];
    logic [DATA_W-1:0] exp_q2[$];
    logic [DATA_W:0]   out_log[$];
    logic              m_rr, m_hold_valid, m_hold_lane, m_stall, m_ovf;
    int                m_drop, m_xfer;
    logic [VW-1:0]     obs_vec, exp_vec;
    logic              obs_lane;
    logic [DATA_W-1:0] obs_data;
    int                total, bad;

    function automatic void model_reset();
        exp_q1.delete();
        exp_q2.delete();
        out_log.delete();
        m_rr = 1'b0;
        m_hold_valid = 1'b0;
        m_hold_lane = 1'b0;
        m_stall = 1'b0;
        m_ovf = 1'b0;
        m_drop = 0;
        m_xfer = 0;
    endfunction

    // driver: one clock cycle; captures observed/expected outputs before the edge
    task automatic step(input logic v1, input logic [DATA_W-1:0] d1,
                        input logic v2, input logic [DATA_W-1:0] d2,
                        input logic rdy);
        logic e_valid, e_lane;
        logic [DATA_W-1:0] e_data;
        in_valid_1 = v1;
        in_data_1  = d1;
        in_valid_2 = v2;
        in_data_2  = d2;
        out_ready  = rdy;
        @(negedge clk);
        e_valid = (exp_q1.size() > 0) || (exp_q2.size() > 0);
        if (m_hold_valid)
            e_lane = m_hold_lane;
        else if (exp_q1.size() > 0 && exp_q2.size() > 0)
            e_lane = m_rr;
        else
            e_lane = (exp_q1.size() == 0);
        e_data = '0;
        if (e_valid) e_data = e_lane ? exp_q2[0] : exp_q1[0];
        exp_vec = {e_valid, e_valid & e_lane, e_data, m_stall, m_ovf, m_drop[7:0], m_xfer[15:0]};
        obs_lane = (out_valid === 1'b1) ? out_lane : 1'b0;
        obs_data = (out_valid === 1'b1) ? out_data : '0;
        obs_vec  = {out_valid, obs_lane, obs_data, global_stall, overflow, drop_count, xfer_count};
        @(posedge clk);
        if (e_valid && rdy) begin
            if (e_lane) void'(exp_q2.pop_front());
            else        void'(exp_q1.pop_front());
            out_log.push_back({e_lane, e_data});
            m_rr = ~e_lane;
            m_xfer++;
            m_hold_valid = 1'b0;
        end else begin
            m_hold_valid = e_valid;
            m_hold_lane  = e_lane;
        end
        if (v1) begin
            if (exp_q1.size() < DEPTH) exp_q1.push_back(d1);
            else begin m_ovf = 1'b1; if (m_drop < 255) m_drop++; end
        end
        if (v2) begin
            if (exp_q2.size() < DEPTH) exp_q2.push_back(d2);
            else begin m_ovf = 1'b1; if (m_drop < 255) m_drop++; end
        end
        m_stall = (exp_q1.size() >= DEPTH - SKID) || (exp_q2.size() >= DEPTH - SKID);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        in_data_1 = '0; in_data_2 = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        in_data_1 = '0; in_data_2 = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++; if (global_stall !== 1'b0) begin bad++; $display("FAIL reset global_stall: got %b want 0", global_stall); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset drop_count: got %0d want 0", drop_count); end
        total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL reset xfer_count: got %0d want 0", xfer_count); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_interleave();
        logic [DATA_W:0] want [6];
        logic stall_seen;
        want[0] = {1'b0, 32'h10}; want[1] = {1'b1, 32'h20};
        want[2] = {1'b0, 32'h11}; want[3] = {1'b1, 32'h21};
        want[4] = {1'b0, 32'h12}; want[5] = {1'b1, 32'h22};
        do_reset();
        stall_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0 && i < 6)
                step(1'b1, 32'h10 + i / 2, 1'b1, 32'h20 + i / 2, 1'b1);
            else
                step(1'b0, '0, 1'b0, '0, 1'b1);
            stall_seen |= (global_stall === 1'b1);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL interleave cyc %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        total++; if (out_log.size() != 6) begin bad++; $display("FAIL interleave count: got %0d want 6", out_log.size()); end
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            total++; if (out_log[i] !== want[i]) begin bad++; $display("FAIL interleave order %0d: got %h want %h", i, out_log[i], want[i]); end
        end
        total++; if (xfer_count !== 16'd6) begin bad++; $display("FAIL interleave xfer_count: got %0d want 6", xfer_count); end
        total++; if (stall_seen !== 1'b0) begin bad++; $display("FAIL interleave stall: got %b want 0", stall_seen); end
    endtask

    task automatic test_stall_response();
        logic g_prev, g_now;
        int rise_at, max_cnt, val;
        g_prev = 1'b0; rise_at = -1; max_cnt = 0; val = 1;
        for (int i = 0; i < 8; i++) begin
            g_now = global_stall;
            if (!g_prev) begin
                step(1'b1, val, 1'b0, '0, 1'b0);
                val++;
            end else begin
                step(1'b0, '0, 1'b0, '0, 1'b0);
            end
            g_prev = g_now;
            if (exp_q1.size() > max_cnt) max_cnt = exp_q1.size();
            if (rise_at < 0 && global_stall === 1'b1) rise_at = exp_q1.size();
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL stall cyc %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        total++; if (rise_at != 2) begin bad++; $display("FAIL stall rise: got count %0d want 2", rise_at); end
        total++; if (max_cnt > 3) begin bad++; $display("FAIL stall depth: got %0d want <=3", max_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stall overflow: got %b want 0", overflow); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL stall drain %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_overflow();
        out_log.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1, 32'hA0 + i, 1'b0);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL overflow fill %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow flag: got %b want 1", overflow); end
        total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL overflow drop_count: got %0d want 2", drop_count); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL overflow drain %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        total++; if (out_log.size() != 4) begin bad++; $display("FAIL overflow drained: got %0d want 4", out_log.size()); end
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            total++; if (out_log[i] !== {1'b1, 32'hA0 + i}) begin bad++; $display("FAIL overflow order %0d: got %h want %h", i, out_log[i], {1'b1, 32'hA0 + i}); end
        end
    endtask

    task automatic test_full_push_pop();
        out_log.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hB0 + i, 1'b0, '0, 1'b0);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL fullpp fill %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        step(1'b1, 32'hB4, 1'b0, '0, 1'b1);
        total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL fullpp push_pop: got %h want %h", obs_vec, exp_vec); end
        total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL fullpp drop_count: got %0d want 2", drop_count); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL fullpp drain %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        total++; if (out_log.size() != 5) begin bad++; $display("FAIL fullpp drained: got %0d want 5", out_log.size()); end
        for (int i = 0; i < 5 && i < out_log.size(); i++) begin
            total++; if (out_log[i] !== {1'b0, 32'hB0 + i}) begin bad++; $display("FAIL fullpp order %0d: got %h want %h", i, out_log[i], {1'b0, 32'hB0 + i}); end
        end
    endtask

    task automatic test_lock();
        out_log.delete();
        step(1'b1, 32'hC0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 32'hD0, 1'b0);
        total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL lock present: got %h want %h", obs_vec, exp_vec); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL lock hold %0d: got %h want %h", i, obs_vec, exp_vec); end
            total++; if ({obs_lane, obs_data} !== {1'b0, 32'hC0}) begin bad++; $display("FAIL lock head %0d: got %h want %h", i, {obs_lane, obs_data}, {1'b0, 32'hC0}); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL lock drain %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        total++; if (out_log.size() != 2) begin bad++; $display("FAIL lock count: got %0d want 2", out_log.size()); end
        else begin
            total++; if (out_log[0] !== {1'b0, 32'hC0}) begin bad++; $display("FAIL lock first: got %h want %h", out_log[0], {1'b0, 32'hC0}); end
            total++; if (out_log[1] !== {1'b1, 32'hD0}) begin bad++; $display("FAIL lock second: got %h want %h", out_log[1], {1'b1, 32'hD0}); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 45), $urandom(),
                 ($urandom_range(0, 99) < 45), $urandom(),
                 ($urandom_range(0, 99) < 65));
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL random cyc %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL random drain %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'hE0, 1'b1, 32'hF0, 1'b0);
        step(1'b1, 32'hE1, 1'b1, 32'hF1, 1'b0);
        #2;
        reset = 1'b0;
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async out_valid: got %b want 0", out_valid); end
        total++; if (global_stall !== 1'b0) begin bad++; $display("FAIL async global_stall: got %b want 0", global_stall); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL async overflow: got %b want 0", overflow); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL async drop_count: got %0d want 0", drop_count); end
        total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL async xfer_count: got %0d want 0", xfer_count); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step((i == 0), 32'hE5, 1'b0, '0, 1'b1);
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL async after %0d: got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_reset();
        test_reset();
        test_interleave();
        test_stall_response();
        test_overflow();
        test_full_push_pop();
        test_lock();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
